// File: rtl/cnt_mod_ud.sv
// Modulo-MODULO up/down counter with synchronous load, registered Zero flag and a
// combinational terminal count for cascading. Define CNT_MOD_UD_OVF_EN to add sticky Ovf/OvfClr.
module cnt_mod_ud #(
  parameter int BUS_SIZE = 4,
  parameter int MODULO   = 10,
  parameter bit CLK_POL  = 1'b0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                En,
  input  logic                Up,
  input  logic                Load,
  input  logic [BUS_SIZE-1:0] D,
  output logic [BUS_SIZE-1:0] Q,
  output logic                Tc,
`ifdef CNT_MOD_UD_OVF_EN
  input  logic                OvfClr,
  output logic                Ovf,
`endif
  output logic                Zero
);

  localparam logic [BUS_SIZE-1:0] MAX_Q = BUS_SIZE'(MODULO - 1);

  generate
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << BUS_SIZE)) begin : g_bad_modulo
      $error("cnt_mod_ud: MODULO %0d not in 2..2**%0d", MODULO, BUS_SIZE);
    end
  endgenerate

  logic                at_max;
  logic                at_min;
  logic [BUS_SIZE-1:0] q_nxt;
  logic                zero_nxt;

  assign at_max = (Q == MAX_Q);
  assign at_min = (Q == '0);

  // Tc is the wrap about to happen on the next active edge; it feeds the next stage's En.
  assign Tc = En & ~Load & ~Rst & ((Up & at_max) | (~Up & at_min));

  // Reset is applied in the register blocks; this is the non-reset next count.
  always_comb begin
    q_nxt = Q;
    if (Load) begin
      q_nxt = (D > MAX_Q) ? MAX_Q : D;
    end else if (En) begin
      if (Up) begin
        q_nxt = at_max ? '0 : Q + BUS_SIZE'(1);
      end else begin
        q_nxt = at_min ? MAX_Q : Q - BUS_SIZE'(1);
      end
    end
  end

  assign zero_nxt = (q_nxt == '0);

`ifdef CNT_MOD_UD_OVF_EN
  logic ovf_nxt;

  // A wrap on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_nxt = Ovf;
    if (Tc) begin
      ovf_nxt = 1'b1;
    end else if (OvfClr) begin
      ovf_nxt = 1'b0;
    end
  end
`endif

  generate
    if (CLK_POL) begin : g_rise
      always_ff @(posedge Clk) begin
        if (Rst) begin
          Q    <= '0;
          Zero <= 1'b1;
`ifdef CNT_MOD_UD_OVF_EN
          Ovf  <= 1'b0;
`endif
        end else begin
          Q    <= q_nxt;
          Zero <= zero_nxt;
`ifdef CNT_MOD_UD_OVF_EN
          Ovf  <= ovf_nxt;
`endif
        end
      end
    end else begin : g_fall
      always_ff @(negedge Clk) begin
        if (Rst) begin
          Q    <= '0;
          Zero <= 1'b1;
`ifdef CNT_MOD_UD_OVF_EN
          Ovf  <= 1'b0;
`endif
        end else begin
          Q    <= q_nxt;
          Zero <= zero_nxt;
`ifdef CNT_MOD_UD_OVF_EN
          Ovf  <= ovf_nxt;
`endif
        end
      end
    end
  endgenerate

endmodule
